// File: rtl/data_slice_sequencer.sv
// Slice sequencer: captures a word on start and streams
// SLICE_W-bit slices for an inclusive index range over valid/ready.
module data_slice_sequencer #(
   parameter int DATA_W  = 15,
   parameter int IDX_W   = 4,
   parameter int SLICE_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [IDX_W-1:0]   start_idx,
   input  logic [IDX_W-1:0]   end_idx,
   input  logic [DATA_W-1:0]  data,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SLICE_W-1:0] slice,
   output logic [IDX_W-1:0]   idx,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  shadow_q, shadow_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   end_q, end_d;
   logic               err_q, err_d;
   logic               legal;
   logic               beat;
   logic [DATA_W-1:0]  shifted;

   // Range must be ordered and the last slice must fit inside the word.
   assign legal = (start_idx <= end_idx) &&
                  ((int'(end_idx) + SLICE_W) <= DATA_W);

   assign beat = (state_q == RUN) && out_ready;

   // State and datapath registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         idx_q    <= '0;
         end_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         end_q    <= end_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic: abort beats a simultaneous beat in RUN.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      end_d    = end_q;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (legal) begin
                  state_d  = RUN;
                  shadow_d = data;
                  idx_d    = start_idx;
                  end_d    = end_idx;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (beat) begin
               if (idx_q == end_q) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slice selection by shift keeps the index in range for any idx.
   always_comb begin
      shifted = shadow_q >> idx_q;
      slice   = shifted[SLICE_W-1:0];
   end

   assign out_valid = (state_q == RUN);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign idx       = idx_q;

endmodule

// File: tb/tb_data_slice_sequencer.sv
// Self-checking bench for data_slice_sequencer.
// Expected slices are queued at start time and popped on beats.
module tb_data_slice_sequencer;

   localparam int DW = 15;
   localparam int IW = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [IW-1:0] start_idx;
   logic [IW-1:0] end_idx;
   logic [DW-1:0] data;
   logic          abort;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] slice;
   logic [IW-1:0] idx;
   logic          busy;
   logic          done;
   logic          err;

   typedef struct packed {
      logic [IW-1:0] i;
      logic [SW-1:0] s;
   } beat_t;

   beat_t sbq[$];
   int    checks = 0;
   int    errors = 0;

   data_slice_sequencer #(
      .DATA_W (DW),
      .IDX_W  (IW),
      .SLICE_W(SW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .start_idx(start_idx),
      .end_idx  (end_idx),
      .data     (data),
      .abort    (abort),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .slice    (slice),
      .idx      (idx),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   function automatic logic [SW-1:0] model_slice(logic [DW-1:0] d, int i);
      logic [DW-1:0] t;
      t = d >> i;
      return t[SW-1:0];
   endfunction

   function automatic bit model_legal(int s, int e);
      return (s <= e) && (e + SW <= DW);
   endfunction

   function automatic void push_scan(logic [DW-1:0] d, int s, int e);
      beat_t b;
      for (int i = s; i <= e; i++) begin
         b.i = IW'(i);
         b.s = model_slice(d, i);
         sbq.push_back(b);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(logic [DW-1:0] d, int s, int e);
      start     = 1'b1;
      data      = d;
      start_idx = IW'(s);
      end_idx   = IW'(e);
      if (model_legal(s, e)) push_scan(d, s, e);
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1; start_idx = 4'd1; end_idx = 4'd3;
      data = 15'h7FFF; abort = 1'b0; out_ready = 1'b1;
      step();
      step();
      checks++;
      if ({out_valid, done, err, busy, idx, slice} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v%b d%b e%b b%b i%0d s%b want all 0",
                  out_valid, done, err, busy, idx, slice);
      end
      start = 1'b0;
      rst = 1'b0;
      step();
      checks++;
      if ({out_valid, done, err, busy} !== 4'b0) begin
         errors++;
         $display("FAIL reset_release got v%b d%b e%b b%b want 0",
                  out_valid, done, err, busy);
      end
   endtask

   task automatic test_illegal();
      int cs[3] = '{5, 4, 0};
      int ce[3] = '{3, 14, 15};
      for (int k = 0; k < 3; k++) begin
         do_start(15'h7FFF, cs[k], ce[k]);
         checks++;
         if (err !== 1'b1 || busy !== 1'b0 || idx !== '0 || slice !== '0) begin
            errors++;
            $display("FAIL illegal_%0d got err%b busy%b idx%0d slice%b want 1 0 0 00",
                     k, err, busy, idx, slice);
         end
         step();
         checks++;
         if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_%0d got err%b busy%b want 0 0",
                     k, err, busy);
         end
      end
   endtask

   task automatic test_basic();
      int n = 0;
      out_ready = 1'b1;
      do_start(15'h5A3C, 0, 3);
      while (sbq.size() > 0 && n < 40) begin
         checks++;
         if (out_valid !== 1'b1 || idx !== sbq[0].i || slice !== sbq[0].s) begin
            errors++;
            $display("FAIL basic_beat got v%b idx%0d slice%b want 1 idx%0d slice%b",
                     out_valid, idx, slice, sbq[0].i, sbq[0].s);
         end
         void'(sbq.pop_front());
         step();
         n++;
      end
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || idx !== 4'd3) begin
         errors++;
         $display("FAIL basic_done got done%b v%b idx%0d want 1 0 3",
                  done, out_valid, idx);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle got done%b busy%b want 0 0", done, busy);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      do_start(15'h0010, 4, 4);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || idx !== sbq[0].i || slice !== sbq[0].s) begin
            errors++;
            $display("FAIL stall_hold_%0d got v%b idx%0d slice%b want 1 idx%0d slice%b",
                     c, out_valid, idx, slice, sbq[0].i, sbq[0].s);
         end
         step();
      end
      out_ready = 1'b1;
      void'(sbq.pop_front());
      step();
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_done got done%b v%b want 1 0", done, out_valid);
      end
      step();
   endtask

   task automatic test_data_change();
      int n = 0;
      out_ready = 1'b1;
      do_start(15'h1234, 0, 13);
      data = 15'h0000;
      while (sbq.size() > 0 && n < 40) begin
         checks++;
         if (out_valid !== 1'b1 || idx !== sbq[0].i || slice !== sbq[0].s) begin
            errors++;
            $display("FAIL shadow_beat got v%b idx%0d slice%b want 1 idx%0d slice%b",
                     out_valid, idx, slice, sbq[0].i, sbq[0].s);
         end
         void'(sbq.pop_front());
         step();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL shadow_done got %b want 1", done);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int n = 0;
      do_start(15'h7FFF, 4, 13);
      start = 1'b1; start_idx = 4'd9; end_idx = 4'd2;
      while (sbq.size() > 0 && n < 200) begin
         out_ready = 1'($urandom_range(0, 1));
         checks++;
         if (out_valid !== 1'b1 || idx !== sbq[0].i ||
             slice !== sbq[0].s || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_beat got v%b idx%0d slice%b err%b want 1 idx%0d slice%b err0",
                     out_valid, idx, slice, err, sbq[0].i, sbq[0].s);
         end
         if (out_ready) void'(sbq.pop_front());
         step();
         n++;
      end
      start = 1'b0;
      checks++;
      if (sbq.size() != 0 || done !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end got left%0d done%b err%b want 0 1 0",
                  sbq.size(), done, err);
      end
      step();
   endtask

   task automatic test_abort();
      int n = 0;
      out_ready = 1'b1;
      do_start(15'h2D6B, 0, 10);
      while (sbq[0].i != 4'd5 && n < 40) begin
         checks++;
         if (out_valid !== 1'b1 || idx !== sbq[0].i || slice !== sbq[0].s) begin
            errors++;
            $display("FAIL abort_beat got v%b idx%0d slice%b want 1 idx%0d slice%b",
                     out_valid, idx, slice, sbq[0].i, sbq[0].s);
         end
         void'(sbq.pop_front());
         step();
         n++;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      sbq.delete();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got v%b busy%b done%b want 0 0 0",
                  out_valid, busy, done);
      end
      do_start(15'h0F0F, 2, 3);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b1 || idx !== sbq[0].i ||
          slice !== sbq[0].s) begin
         errors++;
         $display("FAIL abort_restart got done%b v%b idx%0d slice%b want 0 1 idx%0d slice%b",
                  done, out_valid, idx, slice, sbq[0].i, sbq[0].s);
      end
      void'(sbq.pop_front());
      step();
      void'(sbq.pop_front());
      step();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL abort_restart_done got %b want 1", done);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int n = 0;
      out_ready = 1'b1;
      do_start(15'h7ABC, 0, 10);
      while (sbq[0].i != 4'd7 && n < 40) begin
         void'(sbq.pop_front());
         step();
         n++;
      end
      checks++;
      if (idx !== 4'd7 || slice !== sbq[0].s) begin
         errors++;
         $display("FAIL rstmid_pre got idx%0d slice%b want 7 %b",
                  idx, slice, sbq[0].s);
      end
      rst = 1'b1;
      abort = 1'b1;
      step();
      checks++;
      if ({out_valid, done, err, busy, idx, slice} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs got v%b d%b e%b b%b i%0d s%b want all 0",
                  out_valid, done, err, busy, idx, slice);
      end
      rst = 1'b0;
      abort = 1'b0;
      sbq.delete();
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_nodone got done%b busy%b want 0 0", done, busy);
      end
      do_start(15'h0C30, 2, 3);
      n = 0;
      while (sbq.size() > 0 && n < 20) begin
         checks++;
         if (out_valid !== 1'b1 || idx !== sbq[0].i || slice !== sbq[0].s) begin
            errors++;
            $display("FAIL rstmid_restart got v%b idx%0d slice%b want 1 idx%0d slice%b",
                     out_valid, idx, slice, sbq[0].i, sbq[0].s);
         end
         void'(sbq.pop_front());
         step();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_done got %b want 1", done);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_basic();
      test_stall();
      test_data_change();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
